vga_scan_pipeline: RTL
======================

// Module: vga_scan_pipeline
// PURPOSE
//  Parametrised VGA scan generator: programmable H/V timing and sync polarity, pixel down-scaling
//  (640x480/320x240/160x120 memories) and a read-latency-aligned output pipeline. Optional
//  player-sprite overlay. Sits between the video memory and the VGA DAC, replacing the fixed-timing controller.
// PARAMETERS
//  COLOR_DEPTH  9     bits per stored pixel; BPC = COLOR_DEPTH/3 bits per channel, R in MSBs
//  H_VIS/H_FP/H_SYNC/H_BP  640/16/96/48  horizontal visible/front porch/sync/back porch (clocks)
//  V_VIS/V_FP/V_SYNC/V_BP  480/10/2/33   vertical equivalents (lines)
//  HS_POL, VS_POL  0     sync active level (0 = active-low)
//  SCALE_SH     0     memory pixel = screen pixel >> SCALE_SH (0,1,2)
//  RD_LAT       1     clocks from memory_address to valid pixel_color (1..4)
//  Mn           19    memory_address width
//  SPRITE_SIZE  8     sprite edge in screen pixels; SPRITE_COLOR 9'b000_111_000
// PORTS
//  vga_clock     in   1        pixel clock (25 MHz)
//  reset         in   1        asynchronous, active-high
//  pixel_color   in   COLOR_DEPTH  memory data, valid RD_LAT clocks after address
//  player_x      in   10       sprite left edge, screen pixels
//  player_y      in   9        sprite top edge, screen pixels
//  memory_address out Mn       video memory read address
//  VGA_R/G/B     out  8 each   DAC colour
//  VGA_HS, VGA_VS out 1        syncs, polarity per HS_POL/VS_POL
//  VGA_BLANK_N   out  1        high in visible region
//  VGA_SYNC_N    out  1        constant 1
//  VGA_CLK       out  1        = vga_clock
//  frame_start   out  1        1-clk pulse, output pixel (0,0)
//  vblank_tick   out  1        1-clk pulse, output (h=0, v=V_VIS); game-logic update strobe
// BEHAVIOUR
//  - Counters: h 0..H_TOT-1 (H_TOT=sum of H_*), v increments when h wraps, 0..V_TOT-1, wraps to 0.
//  - Stage 0 = counters. memory_address = (v>>SCALE_SH)*(H_VIS>>SCALE_SH) + (h>>SCALE_SH) when
//    h<H_VIS && v<V_VIS, else 0; registered, so valid one clock after stage 0.
//  - All outputs except VGA_SYNC_N/VGA_CLK/memory_address come from a delay line of depth
//    RD_LAT+1 from stage 0, so colour, HS, VS, BLANK_N of one screen pixel leave together.
//  - HS active for h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1]; VS likewise on v. BLANK_N = visible.
//  - Colour: each BPC-bit channel replicated MSB-first to fill 8 bits, truncated; forced 0 when blanked.
//  - Reset (any time, async): counters 0, pipeline cleared, RGB 0, BLANK_N 0, HS/VS inactive,
//    pulses 0, memory_address 0. Scan restarts at (0,0) on first clock after release.
//  - No handshake; pixel_color sampled blindly RD_LAT clocks after address.
// CONFIGURATION
//  VGA_SPRITE_OVERLAY_EN defined: player_x/player_y latched into shadow regs when stage-0 counters
//   reach (h=0, v=V_VIS); sprite hit = px<=h<px+SIZE && py<=v<py+SIZE (stage 0, delayed with pipe);
//   hit in visible region overrides pixel_color with SPRITE_COLOR. Latch resets to 0.
//  Not defined: player_x/player_y ignored, no shadow regs, output = memory colour only.
// TESTING
//  1 Defaults, RD_LAT=1: HS low exactly 96 of every 800 clks, VS low 2 of 525 lines, BLANK_N high 640 clks/line.
//  2 Reset pulsed mid-line -> all outputs at reset values same clk; first frame_start 2 clks after release.
//  3 SCALE_SH=1: screen (h=2,v=3) -> address 321; each address held 2 consecutive clks, repeated 2 lines.
//  4 RD_LAT=3, memory model returns address as colour: RGB at first visible pixel = colour of address 0, aligned to BLANK_N rise.
//  5 COLOR_DEPTH=9, pixel_color=9'b101_010_111 -> R=8'hB6, G=8'h49, B=8'hFF; blanked -> 0.
//  6 SPRITE_EN, player=(100,50) at vblank, changed to (200,50) mid-frame -> green at h 100..107, v 50..57 until next vblank_tick.

Source files
------------

// File: rtl/vga_scan_pipeline.sv
// VGA scan generator: programmable H/V timing, scaled memory addressing and a read-latency
// aligned output pipe. Player-sprite overlay is built in when VGA_SPRITE_OVERLAY_EN is defined.
module vga_scan_pipeline #(
    parameter int                     COLOR_DEPTH  = 9,
    parameter int                     H_VIS        = 640,
    parameter int                     H_FP         = 16,
    parameter int                     H_SYNC       = 96,
    parameter int                     H_BP         = 48,
    parameter int                     V_VIS        = 480,
    parameter int                     V_FP         = 10,
    parameter int                     V_SYNC       = 2,
    parameter int                     V_BP         = 33,
    parameter bit                     HS_POL       = 1'b0,
    parameter bit                     VS_POL       = 1'b0,
    parameter int                     SCALE_SH     = 0,
    parameter int                     RD_LAT       = 1,
    parameter int                     Mn           = 19,
    parameter int                     SPRITE_SIZE  = 8,
    parameter logic [COLOR_DEPTH-1:0] SPRITE_COLOR = 9'b000_111_000
) (
    input  logic                   vga_clock,
    input  logic                   reset,
    input  logic [COLOR_DEPTH-1:0] pixel_color,
    input  logic [9:0]             player_x,
    input  logic [8:0]             player_y,
    output logic [Mn-1:0]          memory_address,
    output logic [7:0]             VGA_R,
    output logic [7:0]             VGA_G,
    output logic [7:0]             VGA_B,
    output logic                   VGA_HS,
    output logic                   VGA_VS,
    output logic                   VGA_BLANK_N,
    output logic                   VGA_SYNC_N,
    output logic                   VGA_CLK,
    output logic                   frame_start,
    output logic                   vblank_tick
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int BPC   = COLOR_DEPTH / 3;
    localparam int D     = RD_LAT + 1;

    localparam logic [31:0] H_LAST  = H_TOT - 1;
    localparam logic [31:0] V_LAST  = V_TOT - 1;
    localparam logic [31:0] H_VIS_L = H_VIS;
    localparam logic [31:0] V_VIS_L = V_VIS;
    localparam logic [31:0] HS_BEG  = H_VIS + H_FP;
    localparam logic [31:0] HS_END  = H_VIS + H_FP + H_SYNC;
    localparam logic [31:0] VS_BEG  = V_VIS + V_FP;
    localparam logic [31:0] VS_END  = V_VIS + V_FP + V_SYNC;
    localparam logic [31:0] ROW_LEN = H_VIS >> SCALE_SH;

`ifdef VGA_SPRITE_OVERLAY_EN
    localparam int CW = 6;
`else
    localparam int CW = 5;
`endif

    logic [HW-1:0]          r_h;
    logic [VW-1:0]          r_v;
    logic [Mn-1:0]          r_addr;
    logic [CW-1:0]          r_pipe [0:D-1];
    logic [31:0]            w_h32;
    logic [31:0]            w_v32;
    logic                   w_visible;
    logic                   w_hs_act;
    logic                   w_vs_act;
    logic                   w_fs;
    logic                   w_vb;
    logic [Mn-1:0]          w_addr;
    logic [CW-1:0]          w_ctl;
    logic [CW-1:0]          w_out;
    logic [COLOR_DEPTH-1:0] w_pix;
    logic [23:0]            w_rgb;

    assign w_h32     = 32'(r_h);
    assign w_v32     = 32'(r_v);
    assign w_visible = (w_h32 < H_VIS_L) && (w_v32 < V_VIS_L);
    assign w_hs_act  = (w_h32 >= HS_BEG) && (w_h32 < HS_END);
    assign w_vs_act  = (w_v32 >= VS_BEG) && (w_v32 < VS_END);
    assign w_fs      = (w_h32 == 32'd0) && (w_v32 == 32'd0);
    assign w_vb      = (w_h32 == 32'd0) && (w_v32 == V_VIS_L);
    assign w_addr    = Mn'((w_v32 >> SCALE_SH) * ROW_LEN + (w_h32 >> SCALE_SH));

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h32 == H_LAST) begin
            r_h <= '0;
            r_v <= (w_v32 == V_LAST) ? '0 : r_v + VW'(1);
        end else begin
            r_h <= r_h + HW'(1);
        end
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
        end else begin
            r_addr <= w_visible ? w_addr : '0;
        end
    end

`ifdef VGA_SPRITE_OVERLAY_EN
    localparam logic [31:0] SPR_SZ = SPRITE_SIZE;

    logic [9:0] r_px;
    logic [8:0] r_py;
    logic       w_hit;

    // Sprite position is only sampled at the start of vblank so a frame never tears.
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            r_px <= '0;
            r_py <= '0;
        end else if (w_vb) begin
            r_px <= player_x;
            r_py <= player_y;
        end
    end

    assign w_hit = (w_h32 >= 32'(r_px)) && (w_h32 < 32'(r_px) + SPR_SZ) &&
                   (w_v32 >= 32'(r_py)) && (w_v32 < 32'(r_py) + SPR_SZ);
    assign w_ctl = {w_hit, w_vb, w_fs, w_vs_act, w_hs_act, w_visible};
`else
    localparam int unused_sprite_cfg = SPRITE_SIZE + int'(SPRITE_COLOR);
    logic w_unused_player;
    assign w_unused_player = ^{player_x, player_y};
    assign w_ctl = {w_vb, w_fs, w_vs_act, w_hs_act, w_visible};
`endif

    // Control bits travel RD_LAT+1 clocks so they meet the memory data of the same pixel.
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_ctl;
            for (int i = 1; i < D; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_out = r_pipe[D-1];

`ifdef VGA_SPRITE_OVERLAY_EN
    assign w_pix = w_out[5] ? SPRITE_COLOR : pixel_color;
`else
    assign w_pix = pixel_color;
`endif

    // Bit gi of {R,G,B}: channel bits repeat MSB-first across the byte, then truncate.
    genvar gi;
    generate
        for (gi = 0; gi < 24; gi++) begin : g_expand
            assign w_rgb[gi] = w_pix[COLOR_DEPTH - 1 - (2 - gi / 8) * BPC - ((7 - gi % 8) % BPC)];
        end
    endgenerate

    assign memory_address = r_addr;
    assign VGA_R          = w_out[0] ? w_rgb[23:16] : 8'd0;
    assign VGA_G          = w_out[0] ? w_rgb[15:8]  : 8'd0;
    assign VGA_B          = w_out[0] ? w_rgb[7:0]   : 8'd0;
    assign VGA_BLANK_N    = w_out[0];
    assign VGA_HS         = w_out[1] ? HS_POL : ~HS_POL;
    assign VGA_VS         = w_out[2] ? VS_POL : ~VS_POL;
    assign frame_start    = w_out[3];
    assign vblank_tick    = w_out[4];
    assign VGA_SYNC_N     = 1'b1;
    assign VGA_CLK        = vga_clock;

endmodule
